depacketizer: RTL and testbench

DEPACKETIZER -- requirements
Module: depacketizer

---
 rtl/depacketizer.sv | 180 ++++++++++++++++++
 tb/tb_depacketizer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/depacketizer.sv
// Depacketizer: finds a 64-bit preamble (either polarity), decodes mode/length, then forwards payload symbols.
// Latency: every output is registered, one cycle after the accepted input symbol; non-MIX modes pass symbols straight through.
// Backpressure: none; input and output both run at symbol rate, and only cycles with I_tvalid=1 advance state.
module depacketizer #(
    parameter logic [15:0] MAX_PLD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  MODE_CTRL,
    input  logic [1:0]  I_tdata,
    input  logic        I_tvalid,
    output logic [1:0]  O_tdata,
    output logic        O_tvalid,
    output logic        O_tlast,
    output logic        O_tuser,
    output logic [15:0] payload_length,
    output logic        hdr_vld,
    output logic        hdr_err,
    output logic        pld_vld,
    output logic        pkt_rcvd
);

    localparam logic [63:0] PREAMBLE  = 64'h5555_5555_AAAA_AAAA;
    localparam logic [3:0]  MODE_BPSK = 4'b0001;
    localparam logic [3:0]  MODE_MIX  = 4'b0100;

    typedef enum logic [4:0] {
        SEARCH = 5'b00001,
        MODE   = 5'b00010,
        LEN    = 5'b00100,
        TAIL   = 5'b01000,
        PLD    = 5'b10000
    } state_t;

    state_t      state;
    logic [63:0] shreg;
    logic        inv;
    logic        is_bpsk;
    logic [15:0] cnt;
    logic [3:0]  mode_cnt;
    logic [15:0] n_sym;

    logic [1:0]  sym;
    logic [63:0] sh_next;
    logic [3:0]  mode_next;
    logic [15:0] len_next;
    logic [15:0] cnt_inc;

    // The mode field alternates 1,0,1,0,... so the expected bit is the inverse of the count LSB.
    assign sym       = I_tdata ^ {2{inv}};
    assign sh_next   = {shreg[62:0], I_tdata[0]};
    assign mode_next = mode_cnt + {3'b000, (sym[0] == ~cnt[0])};
    assign len_next  = {payload_length[14:0], sym[0]};
    assign cnt_inc   = cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SEARCH;
            shreg          <= '0;
            inv            <= 1'b0;
            is_bpsk        <= 1'b1;
            cnt            <= '0;
            mode_cnt       <= '0;
            n_sym          <= '0;
            payload_length <= '0;
            O_tdata        <= '0;
            O_tvalid       <= 1'b0;
            O_tlast        <= 1'b0;
            O_tuser        <= 1'b0;
            hdr_vld        <= 1'b0;
            hdr_err        <= 1'b0;
            pld_vld        <= 1'b0;
            pkt_rcvd       <= 1'b0;
        end else begin
            hdr_vld  <= 1'b0;
            hdr_err  <= 1'b0;
            pkt_rcvd <= 1'b0;
            O_tlast  <= 1'b0;
            O_tvalid <= 1'b0;
            if (MODE_CTRL != MODE_MIX) begin
                O_tdata  <= I_tdata;
                O_tvalid <= I_tvalid;
                O_tuser  <= (MODE_CTRL == MODE_BPSK);
                pld_vld  <= 1'b1;
                state    <= SEARCH;
                inv      <= 1'b0;
                shreg    <= '0;
                cnt      <= '0;
                mode_cnt <= '0;
            end else begin
                pld_vld <= (state == PLD);
                if (I_tvalid) begin
                    case (state)
                        SEARCH: begin
                            shreg <= sh_next;
                            if (sh_next == PREAMBLE) begin
                                state    <= MODE;
                                inv      <= 1'b0;
                                cnt      <= '0;
                                mode_cnt <= '0;
                            end else if (sh_next == ~PREAMBLE) begin
                                state    <= MODE;
                                inv      <= 1'b1;
                                cnt      <= '0;
                                mode_cnt <= '0;
                            end
                        end
                        MODE: begin
                            if (cnt == 16'd7) begin
                                cnt      <= '0;
                                mode_cnt <= '0;
                                if (mode_next >= 4'd5) begin
                                    is_bpsk <= 1'b1;
                                    state   <= LEN;
                                end else if (mode_next <= 4'd3) begin
                                    is_bpsk <= 1'b0;
                                    state   <= LEN;
                                end else begin
                                    hdr_err <= 1'b1;
                                    state   <= SEARCH;
                                    shreg   <= '0;
                                end
                            end else begin
                                cnt      <= cnt_inc;
                                mode_cnt <= mode_next;
                            end
                        end
                        LEN: begin
                            payload_length <= len_next;
                            if (cnt == 16'd15) begin
                                cnt   <= '0;
                                n_sym <= is_bpsk ? len_next : {1'b0, len_next[15:1]};
                                state <= TAIL;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        TAIL: begin
                            if (cnt == 16'd39) begin
                                cnt <= '0;
                                if (n_sym == 16'd0 || n_sym > MAX_PLD) begin
                                    hdr_err <= 1'b1;
                                    state   <= SEARCH;
                                    shreg   <= '0;
                                end else begin
                                    hdr_vld <= 1'b1;
                                    pld_vld <= 1'b1;
                                    state   <= PLD;
                                end
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        PLD: begin
                            O_tvalid <= 1'b1;
                            O_tuser  <= is_bpsk;
                            O_tdata  <= is_bpsk ? {1'b0, sym[0]} : sym;
                            if (cnt_inc == n_sym) begin
                                O_tlast  <= 1'b1;
                                pkt_rcvd <= 1'b1;
                                pld_vld  <= 1'b0;
                                state    <= SEARCH;
                                shreg    <= '0;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        default: begin
                            state <= SEARCH;
                            shreg <= '0;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_depacketizer.sv
// Directed bench for depacketizer: builds framed symbol streams and checks the recovered payload and header pulses.
module tb_depacketizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  MODE_CTRL;
    logic [1:0]  I_tdata;
    logic        I_tvalid;
    logic [1:0]  O_tdata;
    logic        O_tvalid;
    logic        O_tlast;
    logic        O_tuser;
    logic [15:0] payload_length;
    logic        hdr_vld;
    logic        hdr_err;
    logic        pld_vld;
    logic        pkt_rcvd;

    int checks   = 0;
    int failures = 0;

    logic [1:0] pld [0:31];
    logic [4:0] outq [$];
    int n_hdr_vld = 0;
    int n_hdr_err = 0;
    int n_pkt     = 0;
    bit gap_en    = 1'b0;

    depacketizer dut (
        .clk(clk), .rst(rst), .MODE_CTRL(MODE_CTRL),
        .I_tdata(I_tdata), .I_tvalid(I_tvalid),
        .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tlast(O_tlast), .O_tuser(O_tuser),
        .payload_length(payload_length), .hdr_vld(hdr_vld), .hdr_err(hdr_err),
        .pld_vld(pld_vld), .pkt_rcvd(pkt_rcvd)
    );

    always #5 clk = ~clk;

    // Output monitor; entry = {pkt_rcvd, tlast, tuser, tdata}
    always @(negedge clk) begin
        if (O_tvalid) outq.push_back({pkt_rcvd, O_tlast, O_tuser, O_tdata});
        if (hdr_vld)  n_hdr_vld++;
        if (hdr_err)  n_hdr_err++;
        if (pkt_rcvd) n_pkt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            I_tvalid = 1'b0;
        end
    endtask

    task automatic send_sym(input logic [1:0] d);
        if (gap_en) idle($urandom_range(1, 3));
        @(negedge clk);
        I_tdata  = d;
        I_tvalid = 1'b1;
    endtask

    task automatic send_hdr(input logic [7:0] mode, input logic [15:0] len, input logic inv, input bit with_len);
        logic [63:0] pre;
        pre = 64'h5555_5555_AAAA_AAAA;
        for (int i = 0; i < 64; i++) send_sym({1'b0, pre[63-i]} ^ {inv, inv});
        for (int i = 0; i < 8; i++)  send_sym({1'b0, mode[7-i]} ^ {inv, inv});
        if (with_len) begin
            for (int i = 0; i < 16; i++) send_sym({1'b0, len[15-i]} ^ {inv, inv});
            for (int i = 0; i < 40; i++) send_sym({inv, inv});
        end
    endtask

    task automatic send_pld(input int n, input logic inv);
        for (int i = 0; i < n; i++) send_sym(pld[i] ^ {inv, inv});
    endtask

    task automatic check_out(input string tag, input int start, input int n, input bit bpsk);
        logic [4:0] e;
        logic [1:0] d;
        chk({tag, "_count"}, outq.size() - start, n);
        for (int i = 0; i < n && start + i < outq.size(); i++) begin
            e = outq[start + i];
            d = pld[i];
            chk({tag, "_data"}, e[1:0], bpsk ? {1'b0, d[0]} : d);
            chk({tag, "_user"}, e[2], bpsk);
            chk({tag, "_last"}, e[3], (i == n - 1));
            chk({tag, "_pkt"},  e[4], (i == n - 1));
        end
    endtask

    initial begin
        int s, hv, he, pk;
        for (int i = 0; i < 32; i++) pld[i] = 2'((i * 5 + 1) ^ (i >> 1));

        // Reset overrides a bypass MODE_CTRL with valid input present
        rst = 1'b1; MODE_CTRL = 4'b0001; I_tdata = 2'b11; I_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", O_tvalid, 1'b0);
        chk("rst_pld_vld", pld_vld, 1'b0);
        chk("rst_tuser", O_tuser, 1'b0);
        chk("rst_misc", {O_tdata, O_tlast, hdr_vld, hdr_err, pkt_rcvd}, 5'd0);
        chk("rst_len", payload_length, 16'd0);
        MODE_CTRL = 4'b0100; I_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // BPSK, len 16
        s = outq.size(); hv = n_hdr_vld; he = n_hdr_err; pk = n_pkt;
        send_hdr(8'hAA, 16'd16, 1'b0, 1'b1);
        send_pld(16, 1'b0);
        idle(3);
        chk("bpsk_hdr_vld", n_hdr_vld - hv, 1);
        chk("bpsk_hdr_err", n_hdr_err - he, 0);
        chk("bpsk_pkt", n_pkt - pk, 1);
        chk("bpsk_len", payload_length, 16'd16);
        chk("bpsk_pld_vld_idle", pld_vld, 1'b0);
        check_out("bpsk", s, 16, 1'b1);

        // QPSK, len 20 -> 10 symbols, then again with input gaps
        for (int g = 0; g < 2; g++) begin
            gap_en = (g == 1);
            s = outq.size(); pk = n_pkt;
            send_hdr(8'h55, 16'd20, 1'b0, 1'b1);
            send_pld(10, 1'b0);
            gap_en = 1'b0;
            idle(3);
            chk(g ? "qpsk_gap_pkt" : "qpsk_pkt", n_pkt - pk, 1);
            chk("qpsk_len", payload_length, 16'd20);
            check_out(g ? "qpsk_gap" : "qpsk", s, 10, 1'b0);
        end

        // Inverted stream, BPSK len 8
        s = outq.size(); pk = n_pkt;
        send_hdr(8'hAA, 16'd8, 1'b1, 1'b1);
        send_pld(8, 1'b1);
        idle(3);
        chk("inv_pkt", n_pkt - pk, 1);
        chk("inv_len", payload_length, 16'd8);
        check_out("inv", s, 8, 1'b1);

        // Ambiguous mode field (count 4) then an immediate good packet
        s = outq.size(); hv = n_hdr_vld; he = n_hdr_err;
        send_hdr(8'b1010_0101, 16'd0, 1'b0, 1'b0);
        send_hdr(8'hAA, 16'd4, 1'b0, 1'b1);
        send_pld(4, 1'b0);
        idle(3);
        chk("amb_hdr_err", n_hdr_err - he, 1);
        chk("amb_hdr_vld", n_hdr_vld - hv, 1);
        check_out("amb_next", s, 4, 1'b1);

        // QPSK len 1 -> zero symbols, rejected
        s = outq.size(); hv = n_hdr_vld; he = n_hdr_err;
        send_hdr(8'h55, 16'd1, 1'b0, 1'b1);
        idle(3);
        chk("q1_hdr_err", n_hdr_err - he, 1);
        chk("q1_hdr_vld", n_hdr_vld - hv, 0);
        chk("q1_no_out", outq.size() - s, 0);

        // BPSK len 1 -> single symbol with tlast
        s = outq.size();
        send_hdr(8'hAA, 16'd1, 1'b0, 1'b1);
        send_pld(1, 1'b0);
        idle(3);
        chk("b1_len", payload_length, 16'd1);
        check_out("b1", s, 1, 1'b1);

        // Reset at payload symbol 5 of 16
        s = outq.size(); pk = n_pkt;
        send_hdr(8'hAA, 16'd16, 1'b0, 1'b1);
        send_pld(4, 1'b0);
        @(negedge clk);
        rst = 1'b1; I_tdata = pld[4]; I_tvalid = 1'b1;
        @(negedge clk);
        rst = 1'b0; I_tvalid = 1'b0;
        chk("mid_rst_tvalid", O_tvalid, 1'b0);
        chk("mid_rst_tlast", O_tlast, 1'b0);
        chk("mid_rst_pld_vld", pld_vld, 1'b0);
        idle(3);
        chk("mid_rst_outs", outq.size() - s, 4);
        chk("mid_rst_pkt", n_pkt - pk, 0);
        s = outq.size();
        send_hdr(8'hAA, 16'd16, 1'b0, 1'b1);
        send_pld(16, 1'b0);
        idle(3);
        check_out("after_rst", s, 16, 1'b1);

        // Bypass modes
        MODE_CTRL = 4'b0001;
        send_sym(2'b10);
        idle(1);
        chk("byp_bpsk", {O_tvalid, O_tuser, O_tdata, pld_vld, hdr_vld}, 6'b11_10_1_0);
        MODE_CTRL = 4'b0010;
        send_sym(2'b01);
        idle(1);
        chk("byp_qpsk", {O_tvalid, O_tuser, O_tdata, O_tlast}, 5'b10_01_0);

        // Mode change mid-packet aborts without tlast; next packet is clean
        MODE_CTRL = 4'b0100;
        idle(1);
        s = outq.size(); pk = n_pkt;
        send_hdr(8'hAA, 16'd16, 1'b0, 1'b1);
        send_pld(3, 1'b0);
        @(negedge clk);
        MODE_CTRL = 4'b0010; I_tvalid = 1'b0;
        idle(2);
        MODE_CTRL = 4'b0100;
        idle(1);
        chk("abort_outs", outq.size() - s, 3);
        chk("abort_pkt", n_pkt - pk, 0);
        s = outq.size();
        send_hdr(8'hAA, 16'd16, 1'b0, 1'b1);
        send_pld(16, 1'b0);
        idle(3);
        check_out("reentry", s, 16, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
